// File: rtl/countup_checker_mc.sv
// Multi-channel count-up sequence checker: each channel tracks an expected value,
// latches the first bad sample, counts errors and raises a maskable irq; RBCP register access.
module countup_checker_mc #(
  parameter int          N_CH        = 4,
  parameter int          DATA_WIDTH  = 16,
  parameter logic [31:0] RBCP_OFFSET = 32'h1500_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*DATA_WIDTH-1:0]   data,
  input  logic [N_CH-1:0]              valid,
  output logic                         irq,
  input  logic                         rbcp_we,
  input  logic                         rbcp_re,
  input  logic [31:0]                  rbcp_addr,
  input  logic [7:0]                   rbcp_wd,
  output logic                         rbcp_ack,
  output logic [7:0]                   rbcp_rd
);
  localparam int DW = DATA_WIDTH;

  logic [N_CH-1:0][DW-1:0] exp_q, exp_d, cap_q, cap_d;
  logic [N_CH-1:0][15:0]   err_q, err_d;
  logic [N_CH-1:0]         flag_q, flag_d, en_q, en_d, rsy_q, rsy_d, mask_q, mask_d;
  logic                    irq_q, ack_q;
  logic [7:0]              rd_q, rd_d;

  logic       sel, glb_f0, glb_f1;
  logic [3:0] a_ch, a_reg;
  logic       unused_wd;

  assign sel       = (rbcp_addr[31:8] == RBCP_OFFSET[31:8]);
  assign a_ch      = rbcp_addr[7:4];
  assign a_reg     = rbcp_addr[3:0];
  assign glb_f0    = (rbcp_addr[7:0] == 8'hF0);
  assign glb_f1    = (rbcp_addr[7:0] == 8'hF1);
  assign unused_wd = ^rbcp_wd;

  always_comb begin : chan_next
    logic [DW-1:0] smp;
    logic          cmp;
    logic          wr0;
    smp    = '0;
    cmp    = 1'b0;
    wr0    = 1'b0;
    exp_d  = exp_q;
    cap_d  = cap_q;
    err_d  = err_q;
    flag_d = flag_q;
    en_d   = en_q;
    rsy_d  = rsy_q;
    mask_d = mask_q;
    for (int i = 0; i < N_CH; i++) begin
      smp = data[i*DW +: DW];
      cmp = valid[i] & en_q[i] & (~flag_q[i] | rsy_q[i]);
      wr0 = rbcp_we & sel & (a_ch == 4'(i)) & (a_reg == 4'd0);
      if (cmp) begin
        if (smp == exp_q[i]) begin
          exp_d[i] = exp_q[i] + DW'(1);
        end else begin
          if (!flag_q[i]) begin
            cap_d[i]  = smp;
            flag_d[i] = 1'b1;
          end
          if (err_q[i] != 16'hFFFF) err_d[i] = err_q[i] + 16'd1;
          // Without resync the expected value freezes; the set flag stops further compares.
          if (rsy_q[i]) exp_d[i] = smp + DW'(1);
        end
      end
      if (wr0) begin
        en_d[i]  = rbcp_wd[1];
        rsy_d[i] = rbcp_wd[2];
        if (rbcp_wd[0]) begin
          flag_d[i] = 1'b0;
          err_d[i]  = '0;
          cap_d[i]  = '0;
          exp_d[i]  = smp + DW'(1);
        end
      end
    end
    if (rbcp_we & sel & glb_f0) mask_d = rbcp_wd[N_CH-1:0];
  end

  always_comb begin : rd_next
    logic [31:0] e32, c32;
    e32  = '0;
    c32  = '0;
    rd_d = '0;
    if (sel & rbcp_re) begin
      if (glb_f0) begin
        rd_d = 8'(mask_q);
      end else if (glb_f1) begin
        rd_d = 8'(flag_q);
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (a_ch == 4'(i)) begin
            e32 = 32'(exp_q[i]);
            c32 = 32'(cap_q[i]);
            case (a_reg)
              4'h0:    rd_d = {5'b0, rsy_q[i], en_q[i], flag_q[i]};
              4'h1:    rd_d = e32[7:0];
              4'h2:    rd_d = e32[15:8];
              4'h3:    rd_d = e32[23:16];
              4'h4:    rd_d = e32[31:24];
              4'h5:    rd_d = c32[7:0];
              4'h6:    rd_d = c32[15:8];
              4'h7:    rd_d = c32[23:16];
              4'h8:    rd_d = c32[31:24];
              4'h9:    rd_d = err_q[i][7:0];
              4'hA:    rd_d = err_q[i][15:8];
              default: rd_d = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= '0;
      cap_q  <= '0;
      err_q  <= '0;
      flag_q <= '0;
      en_q   <= '1;
      rsy_q  <= '0;
      mask_q <= '1;
      irq_q  <= 1'b0;
      ack_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      exp_q  <= exp_d;
      cap_q  <= cap_d;
      err_q  <= err_d;
      flag_q <= flag_d;
      en_q   <= en_d;
      rsy_q  <= rsy_d;
      mask_q <= mask_d;
      irq_q  <= |(flag_q & mask_q);
      ack_q  <= sel & (rbcp_we | rbcp_re);
      rd_q   <= rd_d;
    end
  end

  assign irq      = irq_q;
  assign rbcp_ack = ack_q;
  assign rbcp_rd  = rd_q;
endmodule

// File: tb/tb_countup_checker_mc.sv
// Bench for countup_checker_mc: directed scenarios, a constant read table and a
// randomized run checked against a behavioural model.
module tb_countup_checker_mc;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int M   = 1 << DW;
  localparam logic [23:0] SEL = 24'h150000;

  logic        clk = 1'b0;
  logic        rst, rbcp_we, rbcp_re, irq, rbcp_ack;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd, rbcp_rd;
  logic [NCH-1:0] valid;
  logic [15:0] d [NCH];
  logic [NCH*DW-1:0] data;

  assign data = {d[3], d[2], d[1], d[0]};

  countup_checker_mc #(.N_CH(NCH), .DATA_WIDTH(DW), .RBCP_OFFSET(32'h1500_0000)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .irq(irq),
    .rbcp_we(rbcp_we), .rbcp_re(rbcp_re), .rbcp_addr(rbcp_addr), .rbcp_wd(rbcp_wd),
    .rbcp_ack(rbcp_ack), .rbcp_rd(rbcp_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_exp [NCH], m_cap [NCH], m_err [NCH], m_flag [NCH], m_en [NCH], m_rsy [NCH];
  int m_mask, m_irq, m_ack, m_rd;

  typedef struct {
    logic [31:0] addr;
    logic        we, re;
    logic [7:0]  wd;
    logic        ack;
    logic [7:0]  rd;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_read(input logic [31:0] a);
    int c, r, fv;
    if (a[31:8] != SEL) return 0;
    if (a[7:0] == 8'hF0) return m_mask;
    if (a[7:0] == 8'hF1) begin
      fv = 0;
      for (int i = 0; i < NCH; i++) fv += m_flag[i] << i;
      return fv;
    end
    c = int'(a[7:4]);
    r = int'(a[3:0]);
    if (c >= NCH) return 0;
    if (r == 0) return m_rsy[c] * 4 + m_en[c] * 2 + m_flag[c];
    if (r >= 1 && r <= 4) return (m_exp[c] >> (8 * (r - 1))) & 255;
    if (r >= 5 && r <= 8) return (m_cap[c] >> (8 * (r - 5))) & 255;
    if (r == 9) return m_err[c] & 255;
    if (r == 10) return (m_err[c] >> 8) & 255;
    return 0;
  endfunction

  task automatic model_update();
    int ni, na, nr, smp;
    bit sel;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_exp[i] = 0; m_cap[i] = 0; m_err[i] = 0; m_flag[i] = 0; m_en[i] = 1; m_rsy[i] = 0;
      end
      m_mask = M'(0) == 0 ? (1 << NCH) - 1 : 0;
      m_irq = 0; m_ack = 0; m_rd = 0;
      return;
    end
    sel = (rbcp_addr[31:8] == SEL);
    ni = 0;
    for (int i = 0; i < NCH; i++) if (m_flag[i] != 0 && ((m_mask >> i) & 1) != 0) ni = 1;
    na = (sel && (rbcp_we || rbcp_re)) ? 1 : 0;
    nr = (sel && rbcp_re) ? m_read(rbcp_addr) : 0;
    for (int i = 0; i < NCH; i++) begin
      smp = int'(d[i]);
      if (valid[i] && m_en[i] != 0 && (m_flag[i] == 0 || m_rsy[i] != 0)) begin
        if (smp == m_exp[i]) m_exp[i] = (m_exp[i] + 1) % M;
        else begin
          m_err[i] = (m_err[i] < 65535) ? m_err[i] + 1 : 65535;
          if (m_flag[i] == 0) begin m_cap[i] = smp; m_flag[i] = 1; end
          if (m_rsy[i] != 0) m_exp[i] = (smp + 1) % M;
        end
      end
      if (sel && rbcp_we && int'(rbcp_addr[7:4]) == i && rbcp_addr[3:0] == 4'd0) begin
        m_en[i]  = int'(rbcp_wd[1]);
        m_rsy[i] = int'(rbcp_wd[2]);
        if (rbcp_wd[0]) begin
          m_flag[i] = 0; m_err[i] = 0; m_cap[i] = 0; m_exp[i] = (smp + 1) % M;
        end
      end
    end
    if (sel && rbcp_we && rbcp_addr[7:0] == 8'hF0) m_mask = int'(rbcp_wd) % (1 << NCH);
    m_irq = ni; m_ack = na; m_rd = nr;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("irq", irq, m_irq);
    chk("ack", rbcp_ack, m_ack);
    chk("rd", rbcp_rd, m_rd);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    rbcp_we = 0; rbcp_re = 0; rbcp_addr = '0; rbcp_wd = '0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] v);
    rbcp_we = 1; rbcp_addr = a; rbcp_wd = v; step(); idle_bus();
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [7:0] exp);
    rbcp_re = 1; rbcp_addr = a; step();
    chk({nm, "_ack"}, rbcp_ack, 1);
    chk(nm, rbcp_rd, exp);
    idle_bus();
  endtask

  task automatic feed(input int ch, input logic [15:0] v);
    valid = '0; valid[ch] = 1'b1; d[ch] = v; step(); valid = '0;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic we, input logic re,
                              input logic [7:0] wd, input logic ack, input logic [7:0] rd);
    vec_t v;
    v.addr = a; v.we = we; v.re = re; v.wd = wd; v.ack = ack; v.rd = rd;
    return v;
  endfunction

  initial begin
    int r, c;
    rst = 1; valid = '0; idle_bus();
    for (int i = 0; i < NCH; i++) d[i] = '0;
    @(negedge clk);
    do_reset();
    chk("rst_irq", irq, 0);
    chk("rst_ack", rbcp_ack, 0);
    rd_chk("rst_reg0", 32'h1500_0000, 8'h02);
    rd_chk("rst_mask", 32'h1500_00F0, 8'h0F);

    // ch0 full count-up with wrap
    valid = 4'b0001;
    for (int k = 0; k <= 65536; k++) begin d[0] = 16'(k); step(); end
    valid = '0; step();
    chk("wrap_irq", irq, 0);
    rd_chk("wrap_reg0", 32'h1500_0000, 8'h02);
    rd_chk("wrap_err", 32'h1500_0009, 8'h00);
    rd_chk("wrap_exp", 32'h1500_0001, 8'h01);

    // ch1 0,1,2,7,8 without resync
    do_reset();
    feed(1, 16'd0); feed(1, 16'd1); feed(1, 16'd2); feed(1, 16'd7);
    chk("irq_before", irq, 0);
    feed(1, 16'd8);
    chk("irq_after", irq, 1);
    tbl[0]  = mk(32'h1500_0010, 0, 1, 8'h00, 1, 8'h03);
    tbl[1]  = mk(32'h1500_0011, 0, 1, 8'h00, 1, 8'h03);
    tbl[2]  = mk(32'h1500_0012, 0, 1, 8'h00, 1, 8'h00);
    tbl[3]  = mk(32'h1500_0015, 0, 1, 8'h00, 1, 8'h07);
    tbl[4]  = mk(32'h1500_0019, 0, 1, 8'h00, 1, 8'h01);
    tbl[5]  = mk(32'h1500_001A, 0, 1, 8'h00, 1, 8'h00);
    tbl[6]  = mk(32'h1500_00F1, 0, 1, 8'h00, 1, 8'h02);
    tbl[7]  = mk(32'h1500_00F0, 0, 1, 8'h00, 1, 8'h0F);
    tbl[8]  = mk(32'h1500_0042, 0, 1, 8'h00, 1, 8'h00);
    tbl[9]  = mk(32'h1500_001B, 0, 1, 8'h00, 1, 8'h00);
    tbl[10] = mk(32'h1600_0010, 0, 1, 8'h00, 0, 8'h00);
    tbl[11] = mk(32'h1500_0013, 1, 0, 8'h55, 1, 8'h00);
    tbl[12] = mk(32'h1500_0014, 0, 1, 8'h00, 1, 8'h00);
    tbl[13] = mk(32'h1500_0000, 0, 1, 8'h00, 1, 8'h02);
    for (int i = 0; i < 14; i++) begin
      rbcp_addr = tbl[i].addr; rbcp_we = tbl[i].we; rbcp_re = tbl[i].re; rbcp_wd = tbl[i].wd;
      step();
      chk($sformatf("tbl%0d_ack", i), rbcp_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_rd", i), rbcp_rd, tbl[i].rd);
      idle_bus();
    end

    // same stream with resync, then 9,5
    do_reset();
    wr(32'h1500_0010, 8'h06);
    feed(1, 16'd0); feed(1, 16'd1); feed(1, 16'd2); feed(1, 16'd7);
    feed(1, 16'd8); feed(1, 16'd9); feed(1, 16'd5);
    rd_chk("rsy_err", 32'h1500_0019, 8'h02);
    rd_chk("rsy_cap", 32'h1500_0015, 8'h07);
    rd_chk("rsy_exp", 32'h1500_0011, 8'h06);

    // soft reset coincident with a mismatching sample
    chk("sr_irq_pre", irq, 1);
    valid = 4'b0010; d[1] = 16'h0040;
    wr(32'h1500_0010, 8'h07);
    valid = '0;
    chk("sr_irq_hold", irq, 1);
    step();
    chk("sr_irq_low", irq, 0);
    rd_chk("sr_reg0", 32'h1500_0010, 8'h06);
    rd_chk("sr_exp", 32'h1500_0011, 8'h41);
    rd_chk("sr_err", 32'h1500_0019, 8'h00);
    rd_chk("sr_cap", 32'h1500_0015, 8'h00);

    // mask clear, flag vector, out-of-range channel, single-cycle ack
    valid = 4'b0110; d[1] = 16'h0099; d[2] = 16'h0033; step(); valid = '0; step();
    chk("mask_irq_pre", irq, 1);
    wr(32'h1500_00F0, 8'h00);
    step();
    chk("mask_irq_off", irq, 0);
    rd_chk("flagvec", 32'h1500_00F1, 8'h06);
    rd_chk("ch_oob", 32'h1500_0042, 8'h00);
    step();
    chk("ack_once", rbcp_ack, 0);

    // rst during mismatch and read
    valid = 4'b1000; d[3] = 16'h0077; rbcp_re = 1; rbcp_addr = 32'h1500_0030; rst = 1;
    step();
    chk("rst_mid_ack", rbcp_ack, 0);
    chk("rst_mid_rd", rbcp_rd, 0);
    chk("rst_mid_irq", irq, 0);
    rst = 0; valid = '0; idle_bus();
    step();
    chk("rst_no_ack", rbcp_ack, 0);
    rd_chk("rst_flags", 32'h1500_00F1, 8'h00);
    rd_chk("rst_ch3", 32'h1500_0030, 8'h02);
    rd_chk("rst_mask2", 32'h1500_00F0, 8'h0F);

    // randomized run against the model
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        valid[i] = 1'($urandom_range(0, 1));
        d[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(m_exp[i]);
      end
      rst = ($urandom_range(0, 499) == 0);
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 5);
      idle_bus();
      if (r == 0) begin
        rbcp_we = 1; rbcp_addr = {SEL, 4'(c), 4'h0}; rbcp_wd = 8'($urandom_range(0, 7));
      end else if (r == 1) begin
        rbcp_we = 1; rbcp_addr = {SEL, 8'hF0}; rbcp_wd = 8'($urandom);
      end else if (r == 2) begin
        rbcp_we = 1; rbcp_addr = {SEL, 4'(c), 4'($urandom_range(1, 15))}; rbcp_wd = 8'($urandom);
      end else if (r <= 5) begin
        rbcp_re = 1;
        rbcp_addr = {($urandom_range(0, 7) == 0) ? 24'h150001 : SEL, 4'(c), 4'($urandom_range(0, 11))};
        if ($urandom_range(0, 9) == 0) rbcp_addr[7:0] = 8'hF1;
      end
      step();
    end
    rst = 0; valid = '0; idle_bus();
    for (int ch = 0; ch < NCH; ch++)
      for (int rg = 0; rg < 11; rg++) begin
        rbcp_re = 1; rbcp_addr = {SEL, 4'(ch), 4'(rg)}; step();
      end
    idle_bus(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
